regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file: NUM_RD combinational read ports, NUM_WR synchronous write ports.
- Optional hardwired-zero register 0 and write-to-read bypass.
- Per-register busy scoreboard: the issue stage marks a destination pending; writeback clears it.
- Sits between decode/issue (reads, busy checks, destination marking) and writeback (writes) in the pipelined core.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers (power of two, >=2).
- NUM_RD, 3, read ports.
- NUM_WR, 2, write ports.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads.
- RESET_VALUE, 0, value loaded into every register on reset.
- Derived constant (not overridable): AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  packed write addresses; port k occupies bits [k*AW +: AW].
- wr_data  in  NUM_WR*XLEN  packed write data.
- rd_addr  in  NUM_RD*AW  packed read addresses.
- rd_data  out  NUM_RD*XLEN  packed read data.
- rd_busy  out  NUM_RD  scoreboard bit of each read address.
- iss_en  in  1  mark destination busy.
- iss_addr  in  AW  destination being issued.
- busy_vec  out  NUM_REGS  full scoreboard, for debug and stall logic.

Behaviour:
- Reset: on a rising clk edge with rst==0, every register loads RESET_VALUE and every busy bit loads 0. All other inputs are ignored that cycle.
- Outputs during and after reset: rd_data reflects the reset register contents; with ZERO_REG, rd_data for register 0 is 0 regardless of RESET_VALUE. rd_busy = 0. busy_vec = 0.
- Writes: take effect at the rising edge; data is visible on a non-bypassed read the next cycle (latency 1).
- Write conflict: if several enabled write ports target the same address, the highest-index port wins. This is deterministic, not an error.
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - reads of address 0 return 0 with rd_busy=0, bypass included;
  - iss_en with iss_addr=0 is ignored.
- Reads: combinational from rd_addr.
- BYPASS=1: if any enabled write port matches a read address in the current cycle, rd_data returns that port's wr_data (highest matching index) instead of the stored value.
- BYPASS=0: reads return the stored value only.
- Scoreboard, evaluated per register at each rising edge:
  - a write to register r clears busy[r];
  - iss_en with iss_addr==r sets busy[r];
  - set and clear on the same edge: set wins (new producer supersedes the completing one);
  - iss_en to an already-busy register leaves it busy. No counting; the pipeline permits one outstanding producer per register.
- rd_busy[i] = busy[rd_addr[i]].
  - BYPASS=1: rd_busy[i] is forced 0 when the read is bypassed from a same-cycle write to that address, unless iss_en targets the same address that cycle.
  - BYPASS=0: rd_busy[i] reflects the stored busy bit only.
- Out-of-range addresses cannot occur, because NUM_REGS is a power of two.
- Reset mid-operation: pending busy bits and any same-cycle writes are discarded.

Decomposition:
- Shared package/include: XLEN, REG_NUM, AW derivation, RESET_VECTOR, and the data and register-address typedefs, reused by decode and writeback.
- One natural sub-module: rf_scoreboard (busy vector plus set/clear priority), instantiated once.
- Storage, write arbitration and bypass muxes stay in the top module, each built with generate loops over ports.

Test Plan:
- Reset: hold rst=0 for 2 cycles with RESET_VALUE=32'hDEAD_BEEF, then read r5 and r0 -> rd_data r5=DEADBEEF, r0=0, busy_vec=0.
- Write then read: write r3=0x1234 on port0; read r3 the next cycle -> 0x1234.
  - Same-cycle read with BYPASS=1 -> 0x1234 immediately.
  - Same-cycle read with BYPASS=0 -> old value.
- Write conflict: port0 writes r7=0xAAAA and port1 writes r7=0x5555 on the same edge -> r7=0x5555.
- Zero register: write r0=0xFFFF, then iss_en with iss_addr=0 -> r0 reads 0 and busy_vec[0]=0.
- Scoreboard: issue r9 -> busy[9]=1 next cycle.
  - Write r9 with no issue -> busy[9]=0 next cycle.
  - Issue r9 and write r9 on the same edge -> busy[9]=1.
- Reset mid-flight: issue r4 and r6, then assert rst for 1 cycle -> busy_vec=0 and all registers=RESET_VALUE.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared register-file constants and types, also used by decode and writeback.
package regfile_mp_sb_pkg;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int AW      = $clog2(REG_NUM);

    localparam logic [XLEN-1:0] RESET_VECTOR = '0;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [AW-1:0]   regAddr_t;

    // True when the address is the hardwired-zero register and that feature is on.
    function automatic logic isZeroAddr(input int addr, input int zeroReg);
        return (zeroReg != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback clears it.
module rf_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                setEn,
    input  logic [ADDR_W-1:0]   setAddr,
    input  logic [NUM_REGS-1:0] clrVec,
    output logic [NUM_REGS-1:0] busyVec
);

    // Busy bits: a new producer (set) takes priority over a completing one (clear).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            busyVec <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (isZeroAddr(r, ZERO_REG)) begin
                    busyVec[r] <= 1'b0;
                end else if (setEn && (setAddr == ADDR_W'(r))) begin
                    busyVec[r] <= 1'b1;
                end else if (clrVec[r]) begin
                    busyVec[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass and busy scoreboard.
module regfile_mp_sb
    import regfile_mp_sb_pkg::isZeroAddr;
#(
    parameter int              XLEN        = regfile_mp_sb_pkg::XLEN,
    parameter int              NUM_REGS    = regfile_mp_sb_pkg::REG_NUM,
    parameter int              NUM_RD      = 3,
    parameter int              NUM_WR      = 2,
    parameter int              ZERO_REG    = 1,
    parameter int              BYPASS      = 1,
    parameter logic [XLEN-1:0] RESET_VALUE = XLEN'(regfile_mp_sb_pkg::RESET_VECTOR)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_WR-1:0]                     wr_en,
    input  logic [NUM_WR*$clog2(NUM_REGS)-1:0]    wr_addr,
    input  logic [NUM_WR*XLEN-1:0]                wr_data,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]    rd_addr,
    output logic [NUM_RD*XLEN-1:0]                rd_data,
    output logic [NUM_RD-1:0]                     rd_busy,
    input  logic                                  iss_en,
    input  logic [$clog2(NUM_REGS)-1:0]           iss_addr,
    output logic [NUM_REGS-1:0]                   busy_vec
);

    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     regs    [NUM_REGS];
    logic [NUM_REGS-1:0] portHot [NUM_WR];
    logic [NUM_REGS-1:0] wrHit;
    logic [XLEN-1:0]     wrVal   [NUM_REGS];

    // One-hot destination decode per write port, gated by its enable.
    for (genvar k = 0; k < NUM_WR; k++) begin : gWrDec
        assign portHot[k] = wr_en[k] ? (NUM_REGS'(1) << wr_addr[k*AW +: AW]) : '0;
    end

    // Per-register write arbitration: ports scanned low to high so the highest index wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            wrHit[r] = 1'b0;
            wrVal[r] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (portHot[k][r]) begin
                    wrHit[r] = 1'b1;
                    wrVal[r] = wr_data[k*XLEN +: XLEN];
                end
            end
            if (isZeroAddr(r, ZERO_REG)) begin
                wrHit[r] = 1'b0;
            end
        end
    end

    // Register storage: reset loads RESET_VALUE everywhere, otherwise arbitrated writes.
    always_ff @(posedge clk) begin
        // NOTE: this array is flops, not a RAM macro, so resetting every entry is legal and intended.
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= RESET_VALUE;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wrHit[r]) begin
                    regs[r] <= wrVal[r];
                end
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (AW),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .clk     (clk),
        .rst     (rst),
        .setEn   (iss_en),
        .setAddr (iss_addr),
        .clrVec  (wrHit),
        .busyVec (busy_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[i*AW +: AW];

        // Read mux: stored value, then highest matching same-cycle write, then the zero register.
        always_comb begin
            data = regs[addr];
            busy = busy_vec[addr];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == addr)) begin
                        data = wr_data[k*XLEN +: XLEN];
                        // A completing write frees the register unless a new producer claims it now.
                        if (!(iss_en && (iss_addr == addr))) begin
                            busy = 1'b0;
                        end
                    end
                end
            end
            if (isZeroAddr(int'(addr), ZERO_REG)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench: one bypassed and one non-bypassed instance share stimulus.
module tb_regfile_mp_sb;

    localparam int XL  = 32;
    localparam int NR  = 32;
    localparam int NRD = 3;
    localparam int NWR = 2;
    localparam int AWL = 5;
    localparam logic [XL-1:0] RV = 32'hDEAD_BEEF;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NWR-1:0] wrEn;
    logic [AWL-1:0] wrA [NWR];
    logic [XL-1:0]  wrD [NWR];
    logic [AWL-1:0] rdA [NRD];
    logic           issEn;
    logic [AWL-1:0] issA;

    logic [NWR*AWL-1:0] wrAddrBus;
    logic [NWR*XL-1:0]  wrDataBus;
    logic [NRD*AWL-1:0] rdAddrBus;

    logic [NRD*XL-1:0] rdDataB, rdDataN;
    logic [NRD-1:0]    rdBusyB, rdBusyN;
    logic [NR-1:0]     busyB, busyN;

    int checks   = 0;
    int failures = 0;

    assign wrAddrBus = {wrA[1], wrA[0]};
    assign wrDataBus = {wrD[1], wrD[0]};
    assign rdAddrBus = {rdA[2], rdA[1], rdA[0]};

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
        .ZERO_REG(1), .BYPASS(1), .RESET_VALUE(RV)
    ) dutB (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddrBus), .wr_data(wrDataBus),
        .rd_addr(rdAddrBus), .rd_data(rdDataB), .rd_busy(rdBusyB),
        .iss_en(issEn), .iss_addr(issA), .busy_vec(busyB)
    );

    regfile_mp_sb #(
        .XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
        .ZERO_REG(1), .BYPASS(0), .RESET_VALUE(RV)
    ) dutN (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddrBus), .wr_data(wrDataBus),
        .rd_addr(rdAddrBus), .rd_data(rdDataN), .rd_busy(rdBusyN),
        .iss_en(issEn), .iss_addr(issA), .busy_vec(busyN)
    );

    function automatic logic [XL-1:0] rdB(input int i);
        return rdDataB[i*XL +: XL];
    endfunction

    function automatic logic [XL-1:0] rdN(input int i);
        return rdDataN[i*XL +: XL];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wrEn  = '0;
        issEn = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        wrA[0] = '0; wrA[1] = '0; wrD[0] = '0; wrD[1] = '0;
        issA   = '0;
        rdA[0] = 5'd5; rdA[1] = 5'd0; rdA[2] = 5'd0;

        // Reset held for two edges.
        rst = 1'b0;
        tick();
        tick();
        check("reset_r5",       rdB(0), RV);
        check("reset_r0",       rdB(1), 32'h0);
        check("reset_r5_nobyp", rdN(0), RV);
        check("reset_busy_vec", busyB, 32'h0);
        check("reset_rd_busy",  32'(rdBusyB), 32'h0);
        rst = 1'b1;

        // Write r3 on port0, read it in the same cycle and the next.
        wrEn = 2'b01; wrA[0] = 5'd3; wrD[0] = 32'h1234; rdA[0] = 5'd3;
        #1;
        check("wr_r3_bypass_same", rdB(0), 32'h1234);
        check("wr_r3_nobyp_same",  rdN(0), RV);
        check("wr_r3_busy_same",   32'(rdBusyB[0]), 32'h0);
        tick();
        idle();
        #1;
        check("wr_r3_nobyp_next",  rdN(0), 32'h1234);
        check("wr_r3_bypass_next", rdB(0), 32'h1234);

        // Both ports write r7 on one edge: port1 wins.
        wrEn = 2'b11; wrA[0] = 5'd7; wrD[0] = 32'hAAAA; wrA[1] = 5'd7; wrD[1] = 32'h5555;
        rdA[1] = 5'd7;
        #1;
        check("conflict_bypass_same", rdB(1), 32'h5555);
        check("conflict_nobyp_same",  rdN(1), RV);
        tick();
        idle();
        #1;
        check("conflict_r7", rdN(1), 32'h5555);

        // Zero register ignores writes, bypass and issue.
        wrEn = 2'b01; wrA[0] = 5'd0; wrD[0] = 32'hFFFF; rdA[2] = 5'd0;
        #1;
        check("zero_bypass_same", rdB(2), 32'h0);
        tick();
        idle();
        issEn = 1'b1; issA = 5'd0;
        tick();
        idle();
        #1;
        check("zero_read_nobyp", rdN(2), 32'h0);
        check("zero_read_byp",   rdB(2), 32'h0);
        check("zero_busy_vec",   busyB, 32'h0);
        check("zero_rd_busy",    32'(rdBusyB[2]), 32'h0);

        // Issue r9 marks it busy.
        issEn = 1'b1; issA = 5'd9; rdA[0] = 5'd9;
        tick();
        idle();
        #1;
        check("iss_r9_busy_vec",  busyB, 32'h0000_0200);
        check("iss_r9_rd_busy_b", 32'(rdBusyB[0]), 32'h1);
        check("iss_r9_rd_busy_n", 32'(rdBusyN[0]), 32'h1);

        // Writeback to r9 without issue clears it; bypass hides busy in the same cycle.
        wrEn = 2'b10; wrA[1] = 5'd9; wrD[1] = 32'h99;
        #1;
        check("wb_r9_rd_busy_byp",   32'(rdBusyB[0]), 32'h0);
        check("wb_r9_rd_busy_nobyp", 32'(rdBusyN[0]), 32'h1);
        check("wb_r9_data_byp",      rdB(0), 32'h99);
        tick();
        idle();
        #1;
        check("wb_r9_busy_vec", busyB, 32'h0);
        check("wb_r9_data",     rdN(0), 32'h99);

        // Issue and write r9 on the same edge: set wins.
        issEn = 1'b1; issA = 5'd9; wrEn = 2'b01; wrA[0] = 5'd9; wrD[0] = 32'h77;
        tick();
        idle();
        #1;
        check("set_clr_busy_b", busyB, 32'h0000_0200);
        check("set_clr_busy_n", busyN, 32'h0000_0200);
        check("set_clr_data",   rdN(0), 32'h77);

        // r9 busy, bypassed write with re-issue to r9: busy stays visible.
        issEn = 1'b1; issA = 5'd9; wrEn = 2'b01; wrA[0] = 5'd9; wrD[0] = 32'h88;
        #1;
        check("reiss_rd_busy_byp", 32'(rdBusyB[0]), 32'h1);
        check("reiss_data_byp",    rdB(0), 32'h88);
        tick();
        idle();
        #1;
        check("reiss_busy_vec", busyB, 32'h0000_0200);

        // Mid-flight reset discards busy bits, stored data and a same-cycle write/issue.
        issEn = 1'b1; issA = 5'd4;
        tick();
        issA = 5'd6;
        tick();
        idle();
        #1;
        check("midflight_busy_pre", busyB, 32'h0000_0250);
        rdA[0] = 5'd3; rdA[1] = 5'd7; rdA[2] = 5'd12;
        rst = 1'b0;
        wrEn = 2'b01; wrA[0] = 5'd12; wrD[0] = 32'h1;
        issEn = 1'b1; issA = 5'd11;
        tick();
        rst = 1'b1;
        idle();
        #1;
        check("midflight_busy_b", busyB, 32'h0);
        check("midflight_busy_n", busyN, 32'h0);
        check("midflight_r3",     rdN(0), RV);
        check("midflight_r7",     rdN(1), RV);
        check("midflight_r12",    rdN(2), RV);
        check("midflight_rdbusy", 32'(rdBusyB), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
